// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type, state width and the
// decimal-range helper for the shared BCD converter arbiter.
package bcd_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_CONV,
    ST_RESP
  } state_e;

  // 10^(dwidth/4): first value that no longer fits in the
  // available BCD digits.
  function automatic logic [63:0] max_dec(input int dwidth);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < dwidth / 4; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// bcd_dabble_core: sequential double-dabble binary->BCD converter.
// load/operand start a run of BWIDTH steps; done flags the end
// of the run and result holds the packed BCD digits until the
// next load.
module bcd_dabble_core #(
  parameter int BWIDTH = 14,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BWIDTH-1:0] operand,
  output logic              done,
  output logic [DWIDTH-1:0] result
);

  localparam int CW = $clog2(BWIDTH + 1);

  logic [BWIDTH-1:0] sh_q, sh_d;
  logic [DWIDTH-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DWIDTH / 4; i++) begin
      if (bcd_q[i*4 +: 4] > 4'd4) begin
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = operand;
      bcd_d = '0;
      cnt_d = CW'(BWIDTH);
    end else if (cnt_q != '0) begin
      // digits beyond DWIDTH are dropped on purpose
      bcd_d = DWIDTH'({adj, sh_q[BWIDTH-1]});
      sh_d  = {sh_q[BWIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done   = (cnt_q == '0);
  assign result = bcd_q;

endmodule

// File: rtl/bcd_share_arb.sv
// bcd_share_arb: round-robin arbiter sharing one double-dabble
// converter among NREQ requesters (IDLE -> CONV -> RESP).
// Ports: req_valid/req_bin/req_ready per requester; result on
// rsp_valid/rsp_id/rsp_dec with rsp_ready; busy when not IDLE.
// Define BCD_OVF_DETECT_EN to add the rsp_ovf output.
module bcd_share_arb #(
  parameter int NREQ   = 4,
  parameter int BWIDTH = 14,
  parameter int DWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*BWIDTH-1:0]   req_bin,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DWIDTH-1:0]        rsp_dec,
  input  logic                     rsp_ready,
`ifdef BCD_OVF_DETECT_EN
  output logic                     rsp_ovf,
`endif
  output logic                     busy
);

  import bcd_pkg::*;

  localparam int IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     id_q, id_d;
  logic [IW-1:0]     win, idx;
  logic              any, accept, done;
  logic [BWIDTH-1:0] win_op;
  logic [DWIDTH-1:0] result;
  int                t;

  // first asserted request at or after last_q+1, wrapping
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    t   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      t = int'(last_q) + i;
      if (t >= NREQ) t = t - NREQ;
      idx = IW'(t);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  always_comb begin
    win_op = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IW'(k)) win_op = req_bin[k*BWIDTH +: BWIDTH];
    end
  end

  assign req_ready = (state_q == ST_IDLE && any && !rst)
                   ? (NREQ'(1) << win) : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CONV;
          last_d  = win;
          id_d    = win;
        end
      end
      ST_CONV: if (done) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  bcd_dabble_core #(
    .BWIDTH (BWIDTH),
    .DWIDTH (DWIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .operand (win_op),
    .done    (done),
    .result  (result)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign rsp_dec   = rsp_valid ? result : '0;
  assign busy      = (state_q != ST_IDLE);

`ifdef BCD_OVF_DETECT_EN
  localparam logic [63:0] MAXD = max_dec(DWIDTH);
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= (64'(win_op) >= MAXD);
    end
  end

  assign rsp_ovf = rsp_valid & ovf_q;
`endif

endmodule
